bf_out_demux4: RTL and testbench
================================

# bf_out_demux4

Registered 1-to-4 demultiplexer with per-lane buffering on the butterfly-unit output path. Each accepted 32-bit coefficient goes to one of four destination lanes (memory banks / downstream units) by a 2-bit select, so it is the write-side counterpart of the operand-select mux. Each lane has a shallow FIFO, an independent valid/ready handshake, and a frame counter that flags the last coefficient of every 256-coefficient polynomial.

## Interface
- DATA_W, 32, coefficient width
- DEPTH, 2, entries per lane FIFO (power of two, ≥2)
- FRAME_LEN, 256, coefficients per polynomial frame (power of two)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush: empties all FIFOs, zeroes all frame counters
- in_valid  in  1  input word present
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_sel  in  2  destination lane (00→lane0 … 11→lane3)
- in_data  in  DATA_W  coefficient
- out_valid  out  4  per-lane data valid
- out_ready  in  4  per-lane consumer ready
- out_data  out  4×DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- out_last  out  4  lane k's head word is word FRAME_LEN-1 of its frame
- lane_cnt  out  4×log2(FRAME_LEN)  words popped on lane k in the current frame

## Operation
- Push: when in_valid && in_ready, in_data is written to the lane FIFO chosen by in_sel. No other lane changes.
- in_ready = !full[in_sel]. This is combinational from in_sel and registered full flags.
- A full lane refuses input even if it is popping in the same cycle. No full-lane bypass.
- Pop on lane k: out_valid[k] && out_ready[k]. out_valid[k] = !empty[k]. out_data[k] is the FIFO head and is held stable while out_valid[k] && !out_ready[k].
- Simultaneous push and pop on the same non-full lane is allowed. Occupancy is unchanged and FIFO order is preserved.
- Pushes and pops on different lanes are fully independent. All four lanes may pop in one cycle.
- Frame counter: lane_cnt[k] increments on each pop of lane k. It wraps from FRAME_LEN-1 to 0.
- out_last[k] = out_valid[k] && (lane_cnt[k] == FRAME_LEN-1).
- clr takes priority over push and pop in the same cycle. The words involved are discarded, and all counters and pointers go to 0.
- in_sel is ignored when in_valid is low.
- FIFO pointers wrap modulo DEPTH. Occupancy is tracked as a log2(DEPTH)+1-bit count per lane.

## Timing
- Reset (rst_n low, asynchronous): all FIFOs empty, out_valid=0, out_last=0, lane_cnt=0, out_data=0.
  - in_ready is then 1 for any in_sel.
- Latency: a word pushed at edge t is visible on out_valid/out_data of its lane after edge t, i.e. one cycle.
- Throughput: one push per cycle, plus one pop per lane per cycle.
- Full: lane k full after DEPTH pushes with no pop. in_ready drops for in_sel=k only.
- Empty: a pop request (out_ready high) on an empty lane is a no-op. Counter and pointers are unchanged.
- Reset mid-frame: in-flight words are lost and counters restart at 0. No partial-frame recovery.

## Structure
- Shared package (existing butterfly package): DATA_W, LANES=4, FRAME_LEN, and a lane-select typedef (2 bits).
- One sub-module, bf_lane_fifo: DEPTH-entry FIFO with push/pop, full/empty and the frame counter. Instantiate it four times.
- The top level holds only select decode, the in_ready mux and output packing.

## Test plan
- Reset then single push: in_sel=2, in_data=0x0000_1234, out_ready=0 → next cycle out_valid=4'b0100, lane2 data 0x0000_1234. Other lanes invalid.
- Backpressure: 3 pushes to lane 1 with out_ready[1]=0 → first 2 accepted, in_ready=0 on the third. in_ready=1 for in_sel=0.
- Full-lane push+pop: lane1 full, in_valid=1, in_sel=1, out_ready[1]=1 → no accept that cycle, one pop. Accept succeeds next cycle.
- Order and independence: interleave pushes A0,B1,C0,D3 with all out_ready=1 → lane0 emits A then C, lane1 B, lane3 D, each one cycle after its push.
- Frame wrap: stream 256 words to lane 0 → out_last[0] high exactly with word 255, lane_cnt[0] then returns to 0. Word 256 has out_last=0.
- clr with occupied lanes plus a concurrent push → all out_valid=0 and lane_cnt=0 next cycle. The pushed word is not stored.

Source files
------------

// File: rtl/bf_out_demux4_pkg.sv
// Butterfly output-path shared types and sizes.
// Lane count, coefficient width and frame length.
package bf_out_demux4_pkg;
  localparam int DATA_W    = 32;
  localparam int LANES     = 4;
  localparam int FRAME_LEN = 256;

  typedef logic [1:0] lane_sel_t;
endpackage

// File: rtl/bf_lane_fifo.sv
// One demux output lane: shallow FIFO plus
// a frame counter that marks each frame's last word.
module bf_lane_fifo
  import bf_out_demux4_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int FLEN  = 256,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(FLEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop_ready,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic          last,
  output logic          full,
  output logic [CW-1:0] cnt
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = !empty && pop_ready;

  assign valid = !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];
  assign last  = !empty && (cnt == CW'(FLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt    <= cnt + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: empty lanes never expose it
  always_ff @(posedge clk) begin
    if (!clr && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bf_out_demux4.sv
// Registered 1-to-4 demux with per-lane FIFOs
// on the butterfly output path.
module bf_out_demux4
  import bf_out_demux4_pkg::*;
#(
  parameter int DATA_W    = bf_out_demux4_pkg::DATA_W,
  parameter int DEPTH     = 2,
  parameter int FRAME_LEN = bf_out_demux4_pkg::FRAME_LEN,
  localparam int CW       = $clog2(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  lane_sel_t             in_sel,
  input  logic [DATA_W-1:0]     in_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            out_last,
  output logic [4*CW-1:0]       lane_cnt
);

  logic [3:0] full;
  logic [3:0] push;

  assign in_ready = !full[in_sel];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign push[k] = in_valid && in_ready
                     && (in_sel == lane_sel_t'(k));

    bf_lane_fifo #(
      .DW    (DATA_W),
      .DEPTH (DEPTH),
      .FLEN  (FRAME_LEN)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (push[k]),
      .din       (in_data),
      .pop_ready (out_ready[k]),
      .valid     (out_valid[k]),
      .dout      (out_data[k*DATA_W +: DATA_W]),
      .last      (out_last[k]),
      .full      (full[k]),
      .cnt       (lane_cnt[k*CW +: CW])
    );
  end

endmodule

// File: tb/tb_bf_out_demux4.sv
// Directed scoreboard bench for bf_out_demux4.
// Per-lane queues predict pops, counters and flags.
module tb_bf_out_demux4;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int FLEN  = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]    out_last;
  logic [31:0]   lane_cnt;

  bf_out_demux4 #(
    .DATA_W(DW), .DEPTH(DEPTH), .FRAME_LEN(FLEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .lane_cnt(lane_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] q [4][$];
  int mcnt [4];
  int vectors = 0;
  int miscompares = 0;
  int last_hits = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // one clock: check outputs against model, advance
  task automatic cycle();
    bit pop_k [4];
    bit do_push;
    #1;
    for (int k = 0; k < 4; k++) begin
      bit ne;
      ne = (q[k].size() != 0);
      chk($sformatf("valid%0d", k), 64'(out_valid[k]), 64'(ne));
      chk($sformatf("cnt%0d", k),
          64'(lane_cnt[k*8 +: 8]), 64'(mcnt[k]));
      chk($sformatf("last%0d", k), 64'(out_last[k]),
          64'(ne && mcnt[k] == FLEN - 1));
      pop_k[k] = ne && out_ready[k] && !clr;
      if (pop_k[k])
        chk($sformatf("data%0d", k),
            64'(out_data[k*DW +: DW]), 64'(q[k][0]));
    end
    chk("in_ready", 64'(in_ready),
        64'(q[in_sel].size() < DEPTH));
    if (out_last[0] && out_ready[0] && !clr) last_hits++;
    do_push = in_valid && !clr && (q[in_sel].size() < DEPTH);
    @(posedge clk);
    if (clr) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        mcnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (pop_k[k]) begin
          void'(q[k].pop_front());
          mcnt[k] = (mcnt[k] + 1) % FLEN;
        end
      end
      if (do_push) q[in_sel].push_back(in_data);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_sel = 2'd0; in_data = '0; out_ready = 4'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_last", 64'(out_last), 64'h0);
    chk("rst_cnt", 64'(lane_cnt), 64'h0);
    chk("rst_data", 64'(out_data[63:0]), 64'h0);
    chk("rst_data_hi", 64'(out_data[127:64]), 64'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1 chk("rst_ready", 64'(in_ready), 64'h1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // single push to lane 2
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h1234;
    cycle();
    in_valid = 1'b0;
    #1;
    chk("single_valid", 64'(out_valid), 64'h4);
    chk("single_data", 64'(out_data[64 +: 32]), 64'h1234);

    // backpressure on lane 1
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11;
    cycle();
    in_data = 32'h12;
    cycle();
    in_data = 32'h13;
    #1 chk("bp_full", 64'(in_ready), 64'h0);
    in_sel = 2'd0;
    #1 chk("bp_other", 64'(in_ready), 64'h1);
    in_sel = 2'd1;

    // full lane: refuse while popping, accept next cycle
    out_ready = 4'b0010;
    cycle();
    #1 chk("fp_ready", 64'(in_ready), 64'h1);
    cycle();
    in_valid = 1'b0; out_ready = 4'b1111;
    repeat (3) cycle();

    // interleaved order and independence
    in_valid = 1'b1;
    in_sel = 2'd0; in_data = 32'hA; cycle();
    in_sel = 2'd1; in_data = 32'hB; cycle();
    in_sel = 2'd0; in_data = 32'hC; cycle();
    in_sel = 2'd3; in_data = 32'hD; cycle();
    in_valid = 1'b0;
    repeat (2) cycle();

    // frame wrap on lane 0, from a cleared counter
    clr = 1'b1; cycle(); clr = 1'b0;
    out_ready = 4'b0001; in_valid = 1'b1; in_sel = 2'd0;
    last_hits = 0;
    for (int i = 0; i < FLEN + 1; i++) begin
      in_data = 32'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("frame_lasts", 64'(last_hits), 64'h1);
    chk("frame_cnt", 64'(lane_cnt[7:0]), 64'h1);

    // clr with occupied lanes and concurrent push
    out_ready = 4'b0; in_valid = 1'b1;
    in_sel = 2'd0; in_data = 32'h50; cycle();
    in_sel = 2'd1; in_data = 32'h51; cycle();
    in_sel = 2'd3; in_data = 32'h53; cycle();
    clr = 1'b1; in_sel = 2'd2; in_data = 32'h52;
    cycle();
    clr = 1'b0; in_valid = 1'b0;
    #1;
    chk("clr_valid", 64'(out_valid), 64'h0);
    chk("clr_cnt", 64'(lane_cnt), 64'h0);
    out_ready = 4'b1111;
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
